// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions for the instruction loader: request kinds, opcode/func fields,
// loader FSM states and the default text base.
package mips_isa_pkg;

    typedef enum logic [3:0] {
        KindAdd = 4'd0,
        KindSub = 4'd1,
        KindOri = 4'd2,
        KindLw  = 4'd3,
        KindSw  = 4'd4,
        KindBeq = 4'd5,
        KindLui = 4'd6,
        KindJal = 4'd7,
        KindJr  = 4'd8
    } reqKindT;

    typedef enum logic [1:0] {
        StLoad,
        StDrain,
        StSealed
    } loaderStateT;

    localparam logic [5:0] OpcRType = 6'h00;
    localparam logic [5:0] OpcOri   = 6'h0D;
    localparam logic [5:0] OpcLw    = 6'h23;
    localparam logic [5:0] OpcSw    = 6'h2B;
    localparam logic [5:0] OpcBeq   = 6'h04;
    localparam logic [5:0] OpcLui   = 6'h0F;
    localparam logic [5:0] OpcJal   = 6'h03;

    localparam logic [5:0] FuncAdd  = 6'h20;
    localparam logic [5:0] FuncSub  = 6'h22;
    localparam logic [5:0] FuncJr   = 6'h08;

    localparam logic [31:0] TextBase = 32'h0000_3000;

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational encoder: one symbolic request plus its destination pc into a MIPS word,
// flagging requests the core could not execute as written.
module mips_instr_encode
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [31:0] target,
    input  logic [31:0] pc,
    output logic [31:0] word,
    output logic        reject
);

    logic [32:0]        pcPlus4;
    logic [32:0]        diff;
    logic signed [32:0] off;
    logic               offInRange;
    logic               targetAligned;
    logic               jalSameRegion;

    // Branch displacement is taken relative to the delay-slot address in 33-bit signed math.
    always_comb begin
        pcPlus4       = {1'b0, pc} + 33'd4;
        diff          = {1'b0, target} - pcPlus4;
        off           = $signed(diff) >>> 2;
        offInRange    = (&off[32:15]) || (~|off[32:15]);
        targetAligned = (target[1:0] == 2'b00);
        jalSameRegion = (target[31:28] == pcPlus4[31:28]);
    end

    always_comb begin
        word   = '0;
        reject = 1'b0;
        case (kind)
            KindAdd: word = {OpcRType, rs, rt, rd, 5'h00, FuncAdd};
            KindSub: word = {OpcRType, rs, rt, rd, 5'h00, FuncSub};
            KindOri: word = {OpcOri, rs, rt, imm};
            KindLw:  word = {OpcLw, rs, rt, imm};
            KindSw:  word = {OpcSw, rs, rt, imm};
            KindLui: word = {OpcLui, 5'h00, rt, imm};
            KindBeq: begin
                word   = {OpcBeq, rs, rt, off[15:0]};
                reject = !targetAligned || !offInRange;
            end
            KindJal: begin
                word   = {OpcJal, target[27:2]};
                reject = !targetAligned || !jalSameRegion;
            end
            KindJr:  word = {OpcRType, rs, 15'h0000, FuncJr};
            default: reject = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Streams encoded instructions into instruction memory at consecutive word addresses,
// one request per handshake, through a single output register.
module imem_program_loader
    import mips_isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = TextBase,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_kind,
    input  logic [4:0]            req_rs,
    input  logic [4:0]            req_rt,
    input  logic [4:0]            req_rd,
    input  logic [15:0]           req_imm,
    input  logic [31:0]           req_target,
    input  logic                  seal,
    output logic                  sealed,
    output logic                  im_we,
    output logic [31:0]           im_addr,
    output logic [31:0]           im_wdata,
    input  logic                  im_ready,
    output logic [DEPTH_LOG2:0]   word_count,
    output logic                  full,
    output logic                  err
);

    localparam logic [DEPTH_LOG2:0] CapacityWords = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CountOne      = {{DEPTH_LOG2{1'b0}}, 1'b1};

    loaderStateT           stateQ, stateD;
    logic [31:0]           pcQ;
    logic [DEPTH_LOG2:0]   acceptedQ;
    logic [DEPTH_LOG2:0]   wordCountQ;
    logic                  imWeQ;
    logic [31:0]           imAddrQ;
    logic [31:0]           imWdataQ;
    logic                  errQ;

    logic                  capReached;
    logic                  reqReadyInt;
    logic                  accept;
    logic                  handshake;
    logic [31:0]           encWord;
    logic                  encReject;

    mips_instr_encode u_encode (
        .kind   (req_kind),
        .rs     (req_rs),
        .rt     (req_rt),
        .rd     (req_rd),
        .imm    (req_imm),
        .target (req_target),
        .pc     (pcQ),
        .word   (encWord),
        .reject (encReject)
    );

    // acceptedQ counts the pending word too, so capacity closes before the last write lands.
    always_comb begin
        capReached  = (acceptedQ == CapacityWords);
        handshake   = imWeQ && im_ready;
        reqReadyInt = (stateQ == StLoad) && !capReached && (!imWeQ || im_ready);
        accept      = req_valid && reqReadyInt;
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StLoad:   if (seal) stateD = StDrain;
            StDrain:  if (!imWeQ || handshake) stateD = StSealed;
            StSealed: stateD = StSealed;
            default:  stateD = StLoad;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StLoad;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcQ        <= BASE_ADDR;
            acceptedQ  <= '0;
            wordCountQ <= '0;
            imWeQ      <= 1'b0;
            imAddrQ    <= BASE_ADDR;
            imWdataQ   <= '0;
            errQ       <= 1'b0;
        end else begin
            if (handshake) begin
                wordCountQ <= wordCountQ + CountOne;
            end
            // A new word replaces a just-handshaken one with no bubble.
            if (accept && !encReject) begin
                imWeQ     <= 1'b1;
                imAddrQ   <= pcQ;
                imWdataQ  <= encWord;
                pcQ       <= pcQ + 32'd4;
                acceptedQ <= acceptedQ + CountOne;
            end else if (handshake) begin
                imWeQ <= 1'b0;
            end
            if (accept && encReject) begin
                errQ <= 1'b1;
            end
        end
    end

    always_comb begin
        req_ready  = reqReadyInt;
        sealed     = (stateQ == StSealed);
        im_we      = imWeQ;
        im_addr    = imAddrQ;
        im_wdata   = imWdataQ;
        word_count = wordCountQ;
        full       = (wordCountQ == CapacityWords);
        err        = errQ;
    end

endmodule

// File: doc/imem_program_loader.md
# imem_program_loader

Sequential instruction encoder and writer for the single-cycle MIPS core. Accepts one symbolic instruction request per handshake and encodes it into a 32-bit MIPS word. The encoded subset is exactly the one the core's control decoder recognises: add, sub, ori, lw, sw, beq, lui, jal, jr. Each word is streamed into instruction memory at consecutive word addresses starting at the text base. The block is the producer side of the instruction word format; it is used for boot-time program loading and by testbenches.

## Interface
- BASE_ADDR, 32'h0000_3000, byte address of the first word written.
- DEPTH_LOG2, 10, log2 of instruction memory capacity in words.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle where valid && ready.
- req_kind  in  4  0 ADD, 1 SUB, 2 ORI, 3 LW, 4 SW, 5 BEQ, 6 LUI, 7 JAL, 8 JR; 9–15 illegal.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  16  immediate for ORI/LW/SW/LUI.
- req_target  in  32  absolute byte target for BEQ/JAL.
- seal  in  1  level; request end of program.
- sealed  out  1  loading finished; no further requests are accepted.
- im_we  out  1  write strobe, held until im_ready.
- im_addr  out  32  byte address of the word.
- im_wdata  out  32  encoded word.
- im_ready  in  1  memory accepts the write this cycle.
- word_count  out  DEPTH_LOG2+1  words written (handshaken).
- full  out  1  word_count == 2**DEPTH_LOG2.
- err  out  1  sticky; set by any rejected request.

## Operation
- Encodings:
  - ADD/SUB: {6'h00, rs, rt, rd, 5'h0, func}, with func 6'h20 or 6'h22.
  - ORI: {6'h0D, rs, rt, imm}.
  - LW: {6'h23, rs, rt, imm}.
  - SW: {6'h2B, rs, rt, imm}.
  - LUI: {6'h0F, 5'h0, rt, imm}.
  - BEQ: {6'h04, rs, rt, off16}, where off = (req_target − (pc+4)) >>> 2, computed in signed 33-bit arithmetic.
  - JAL: {6'h03, req_target[27:2]}.
  - JR: {6'h00, rs, 15'h0, 6'h08}.
- pc is the address the word will occupy: BASE_ADDR + 4·(words accepted so far, including any word held in the output register).
- Rejection. A request is consumed, not written, and sets err when any of these hold:
  - req_kind is illegal;
  - BEQ/JAL with req_target[1:0] ≠ 0;
  - BEQ with off outside [−32768, 32767];
  - JAL with req_target[31:28] ≠ (pc+4)[31:28].
  - A rejected request does not advance pc.
- FSM states:
  - LOAD: accepting requests. Go to DRAIN when seal=1.
  - DRAIN: req_ready=0. Go to SEALED once the output register is empty.
  - SEALED: sealed=1 and req_ready=0. Only reset leaves this state.
- Capacity:
  - When the accepted-word count (including a pending word) reaches 2**DEPTH_LOG2, req_ready=0. There is no address wrap.
  - full reflects handshaken words only.

## Timing
- Reset values: FSM=LOAD, im_we=0, im_addr=BASE_ADDR, im_wdata=0, word_count=0, full=0, err=0, sealed=0, pc=BASE_ADDR.
- Latency: a request accepted at edge N drives im_we=1 with its addr/wdata from N+1 until the im_ready handshake.
- Single output register.
  - req_ready = FSM==LOAD && !capacity_reached && (!im_we || im_ready). This sustains 1 word/cycle when im_ready=1.
  - While im_we=1 && !im_ready, im_addr and im_wdata are held stable.
- word_count increments on the im_we && im_ready edge.
- A rejected request is accepted under the same req_ready rule, but loads nothing and leaves im_we unchanged.
- Simultaneous events:
  - seal together with an accepted request: the request is taken, then the FSM enters DRAIN.
  - Handshake and new accept in the same cycle: the output register is replaced with no bubble.
- Reset mid-operation discards any pending word immediately; im_we drops asynchronously.

## Structure
- Shared package `mips_isa_pkg` holds:
  - req_kind enum;
  - opcode/func constants (6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h03, 6'h20, 6'h22, 6'h08);
  - BASE_ADDR default.
- Sub-module `mips_instr_encode` is purely combinational. It takes kind, fields, target and pc, and returns word and reject.
- The top level holds the FSM, pc, output register and counters.

## Test plan
- At reset, ADD rs=1 rt=2 rd=3 -> im_addr 0x3000, im_wdata 0x00221820, im_we on the next cycle.
- ORI rs=0 rt=1 imm=0x1234 at 0x3004; then BEQ rs=rt=0 target=0x3000 at 0x3008 -> words 0x34011234 and 0x1000FFFD.
- Fresh reset; LUI rt=2 imm=0xABCD, then JR rs=31, then JAL target=0x3010 (at 0x3008) -> 0x3C02ABCD, 0x03E00008, 0x0C000C04; word_count=3.
- im_ready held low 3 cycles with im_we=1 -> addr/wdata stable, req_ready=0; after release, a back-to-back stream runs at 1 word/cycle.
- req_kind=12 and BEQ target=0x3002 -> err=1, no write, pc unchanged; the next valid ADD lands at the unchanged address.
- DEPTH_LOG2=2:
  - 4 words written -> full=1, req_ready=0.
  - seal -> sealed=1 after drain.
  - reset with a word pending -> im_we=0 and all outputs at reset values.
